// File: rtl/seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl
//
// Time-multiplexed scan controller for an 8-digit common-anode 7-segment
// display. It holds an 8-nibble display window plus a decimal-point mask and
// lights one digit at a time. Each digit slot starts with an all-anodes-off
// blanking interval to suppress ghosting. New windows may be loaded at any
// time but only become visible at a frame boundary, so a frame never shows a
// mix of two windows.
//
// Ports:
//   clk        - system clock, rising edge
//   rst_n      - asynchronous active-low reset
//   en         - scan enable; 0 forces the display dark
//   load       - one-cycle strobe capturing load_data/load_dp as pending
//   load_data  - eight nibbles, [31:28] = leftmost digit (AN[7])
//   load_dp    - decimal-point enables, bit i = DP of digit on AN[i]
//   digit      - nibble to the 7-segment decoder
//   dp_n       - decimal point, active low
//   AN         - digit enables, active low, at most one bit low
//   frame_done - one-cycle pulse in the last cycle of each completed frame
//
// Timing notes:
//   Every output is a register loaded from the *next* state, so the outputs
//   always describe the state the controller is currently in.
//   The frame boundary is the clock edge that enters BLANK with idx=0. The
//   cycle ending at that edge is the "boundary cycle": frame_done is high in
//   it (for a wrap from SHOW idx 7 only), and a load strobed in it goes
//   straight to the active window instead of the pending one.
// -----------------------------------------------------------------------------
module seg_scan_ctrl #(
    parameter int REFRESH_DIV = 100_000,
    parameter int BLANK_CYC   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        load,
    input  logic [31:0] load_data,
    input  logic [7:0]  load_dp,
    output logic [3:0]  digit,
    output logic        dp_n,
    output logic [7:0]  AN,
    output logic        frame_done
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    // Nibble for scan position idx; idx 0 is the leftmost digit.
    function automatic logic [3:0] pick_nibble(input logic [31:0] data,
                                               input logic [2:0]  idx);
        logic [3:0] nib;
        case (idx)
            3'd0:    nib = data[31:28];
            3'd1:    nib = data[27:24];
            3'd2:    nib = data[23:20];
            3'd3:    nib = data[19:16];
            3'd4:    nib = data[15:12];
            3'd5:    nib = data[11:8];
            3'd6:    nib = data[7:4];
            3'd7:    nib = data[3:0];
            default: nib = 4'h0;
        endcase
        return nib;
    endfunction

    state_t           state_r, state_s;
    logic [2:0]       idx_r, idx_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             boundary_s;

    logic [31:0]      active_data_r, active_data_s;
    logic [7:0]       active_dp_r, active_dp_s;
    logic [31:0]      pend_data_r, pend_data_s;
    logic [7:0]       pend_dp_r, pend_dp_s;
    logic             pend_r, pend_s;

    logic [2:0]       an_pos_s;
    logic [7:0]       an_s;
    logic [3:0]       digit_s;
    logic             dp_n_s;
    logic             frame_done_s;

    // Next-state logic: slot counter, digit index and frame-boundary detect.
    always_comb begin
        state_s    = state_r;
        idx_s      = idx_r;
        cnt_s      = cnt_r;
        boundary_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                idx_s = 3'd0;
                cnt_s = '0;
                if (en) begin
                    // Starting a scan is always a frame boundary.
                    state_s    = ST_BLANK;
                    boundary_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BLANK, ST_SHOW: begin
                if (!en) begin
                    state_s = ST_IDLE;
                    idx_s   = 3'd0;
                    cnt_s   = '0;
                end else if (cnt_r == CNT_LAST) begin
                    state_s    = ST_BLANK;
                    idx_s      = idx_r + 3'd1;
                    cnt_s      = '0;
                    boundary_s = (idx_r == 3'd7);
                end else begin
                    cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    if ((state_r == ST_BLANK) && (cnt_r == BLANK_LAST)) begin
                        state_s = ST_SHOW;
                    end else begin
                        state_s = state_r;
                    end
                end
            end
            default: begin
                state_s = ST_IDLE;
                idx_s   = 3'd0;
                cnt_s   = '0;
            end
        endcase
    end

    // Window update: loads park in pending; the boundary promotes them.
    always_comb begin
        active_data_s = active_data_r;
        active_dp_s   = active_dp_r;
        pend_data_s   = pend_data_r;
        pend_dp_s     = pend_dp_r;
        pend_s        = pend_r;
        if (boundary_s) begin
            pend_s = 1'b0;
            if (load) begin
                // A load in the boundary cycle bypasses pending entirely.
                active_data_s = load_data;
                active_dp_s   = load_dp;
                pend_data_s   = load_data;
                pend_dp_s     = load_dp;
            end else if (pend_r) begin
                active_data_s = pend_data_r;
                active_dp_s   = pend_dp_r;
            end else begin
                active_data_s = active_data_r;
                active_dp_s   = active_dp_r;
            end
        end else if (load) begin
            pend_data_s = load_data;
            pend_dp_s   = load_dp;
            pend_s      = 1'b1;
        end else begin
            pend_s = pend_r;
        end
    end

    // Output decode from the next state so the registered outputs line up.
    always_comb begin
        an_s         = 8'hFF;
        digit_s      = 4'h0;
        dp_n_s       = 1'b1;
        frame_done_s = 1'b0;
        an_pos_s     = 3'd7 - idx_s;
        case (state_s)
            ST_IDLE: begin
                an_s = 8'hFF;
            end
            ST_BLANK: begin
                // Decoder input settles while every anode is still off.
                digit_s = pick_nibble(active_data_s, idx_s);
            end
            ST_SHOW: begin
                digit_s        = pick_nibble(active_data_s, idx_s);
                an_s[an_pos_s] = 1'b0;
                dp_n_s         = ~active_dp_s[an_pos_s];
                frame_done_s   = (idx_s == 3'd7) && (cnt_s == CNT_LAST);
            end
            default: begin
                an_s = 8'hFF;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            idx_r   <= 3'd0;
            cnt_r   <= '0;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            cnt_r   <= cnt_s;
        end
    end

    // Active and pending window registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_data_r <= 32'h0000_0000;
            active_dp_r   <= 8'h00;
            pend_data_r   <= 32'h0000_0000;
            pend_dp_r     <= 8'h00;
            pend_r        <= 1'b0;
        end else begin
            active_data_r <= active_data_s;
            active_dp_r   <= active_dp_s;
            pend_data_r   <= pend_data_s;
            pend_dp_r     <= pend_dp_s;
            pend_r        <= pend_s;
        end
    end

    // Registered display outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            AN         <= 8'hFF;
            digit      <= 4'h0;
            dp_n       <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            AN         <= an_s;
            digit      <= digit_s;
            dp_n       <= dp_n_s;
            frame_done <= frame_done_s;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_ctrl
//
// Self-checking bench for seg_scan_ctrl with REFRESH_DIV=8, BLANK_CYC=2.
// The reference model tracks only "cycles since the scan started" and derives
// digit position, blanking and frame boundaries from it arithmetically.
// -----------------------------------------------------------------------------
module tb_seg_scan_ctrl;

    localparam int RD    = 8;
    localparam int BC    = 2;
    localparam int FRAME = 8 * RD;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        load;
    logic [31:0] load_data;
    logic [7:0]  load_dp;
    logic [3:0]  digit;
    logic        dp_n;
    logic [7:0]  AN;
    logic        frame_done;

    int total_cnt;
    int bad_cnt;

    // Reference model state.
    bit          m_run;
    int          m_t;
    logic [31:0] m_act;
    logic [7:0]  m_act_dp;
    logic [31:0] m_pnd;
    logic [7:0]  m_pnd_dp;
    bit          m_pend;

    seg_scan_ctrl #(
        .REFRESH_DIV (RD),
        .BLANK_CYC   (BC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .load       (load),
        .load_data  (load_data),
        .load_dp    (load_dp),
        .digit      (digit),
        .dp_n       (dp_n),
        .AN         (AN),
        .frame_done (frame_done)
    );

    // 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        total_cnt++;
        if (obs !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run    = 1'b0;
        m_t      = 0;
        m_act    = 32'h0;
        m_act_dp = 8'h0;
        m_pnd    = 32'h0;
        m_pnd_dp = 8'h0;
        m_pend   = 1'b0;
    endtask

    function automatic int model_pos();
        return m_t % FRAME;
    endfunction

    // Advance the model by one clock edge using the inputs in force.
    task automatic model_step();
        bit boundary;
        boundary = 1'b0;
        if (!m_run) begin
            if (en) begin
                m_run    = 1'b1;
                m_t      = 0;
                boundary = 1'b1;
            end
        end else if (!en) begin
            m_run = 1'b0;
            m_t   = 0;
        end else begin
            m_t = m_t + 1;
            boundary = ((m_t % FRAME) == 0);
        end
        if (boundary) begin
            if (load) begin
                m_act    = load_data;
                m_act_dp = load_dp;
            end else if (m_pend) begin
                m_act    = m_pnd;
                m_act_dp = m_pnd_dp;
            end
            m_pend = 1'b0;
        end else if (load) begin
            m_pnd    = load_data;
            m_pnd_dp = load_dp;
            m_pend   = 1'b1;
        end
    endtask

    task automatic check_outputs();
        int p, idx, w;
        logic [31:0] e_an, e_digit, e_dp, e_fd;
        e_an = 32'hFF; e_digit = 32'h0; e_dp = 32'h1; e_fd = 32'h0;
        if (m_run) begin
            p       = model_pos();
            idx     = p / RD;
            w       = p % RD;
            e_digit = (m_act >> (28 - 4 * idx)) & 32'hF;
            if (w >= BC) begin
                e_an = 32'hFF & ~(32'h1 << (7 - idx));
                e_dp = {31'h0, ~m_act_dp[7 - idx]};
            end
            e_fd = (p == FRAME - 1) ? 32'h1 : 32'h0;
        end
        check_val("AN",         {24'h0, AN},         e_an);
        check_val("digit",      {28'h0, digit},      e_digit);
        check_val("dp_n",       {31'h0, dp_n},       e_dp);
        check_val("frame_done", {31'h0, frame_done}, e_fd);
    endtask

    // One clock: drive inputs, step model at the edge, check at the negedge.
    task automatic run_cycle(input logic e, input logic l,
                             input logic [31:0] d, input logic [7:0] dp);
        en        = e;
        load      = l;
        load_data = d;
        load_dp   = dp;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    // Assert reset between edges and check the outputs go dark at once.
    task automatic async_reset();
        en   = 1'b0;
        load = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_val("rst_AN",    {24'h0, AN},         32'hFF);
        check_val("rst_dp_n",  {31'h0, dp_n},       32'h1);
        check_val("rst_digit", {28'h0, digit},      32'h0);
        check_val("rst_fd",    {31'h0, frame_done}, 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Idle with en high until the model reaches frame position p.
    task automatic run_to_pos(input int p);
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (m_run && model_pos() == p) break;
            run_cycle(1'b1, 1'b0, 32'h0, 8'h0);
        end
    endtask

    initial begin
        total_cnt = 0;
        bad_cnt   = 0;
        rst_n     = 1'b0;
        en        = 1'b0;
        load      = 1'b0;
        load_data = 32'h0;
        load_dp   = 8'h0;
        model_reset();
        repeat (3) @(negedge clk);
        check_outputs();
        rst_n = 1'b1;
        run_cycle(1'b0, 1'b0, 32'h0, 8'h0);

        // Load a window, then enable: visible from the first boundary.
        run_cycle(1'b0, 1'b1, 32'h1135_1127, 8'h01);
        for (int i = 0; i < 2 * FRAME + 10; i++) run_cycle(1'b1, 1'b0, 32'h0, 8'h0);

        // Mid-frame load at idx 3 waits for the next frame.
        run_to_pos(3 * RD + 3);
        run_cycle(1'b1, 1'b1, 32'h0081_5F18, 8'hA5);
        for (int i = 0; i < FRAME + 20; i++) run_cycle(1'b1, 1'b0, 32'h0, 8'h0);

        // Two loads in one frame: the later one wins.
        run_to_pos(RD + 4);
        run_cycle(1'b1, 1'b1, 32'hAAAA_AAAA, 8'hFF);
        run_to_pos(5 * RD + 1);
        run_cycle(1'b1, 1'b1, 32'h5555_5555, 8'h3C);
        for (int i = 0; i < FRAME + 10; i++) run_cycle(1'b1, 1'b0, 32'h0, 8'h0);

        // Load in the wrap cycle goes straight into the new frame.
        run_to_pos(FRAME - 1);
        run_cycle(1'b1, 1'b1, 32'h9876_5432, 8'h81);
        for (int i = 0; i < FRAME; i++) run_cycle(1'b1, 1'b0, 32'h0, 8'h0);

        // Drop en during SHOW idx 5, then re-enable.
        run_to_pos(5 * RD + 4);
        run_cycle(1'b0, 1'b0, 32'h0, 8'h0);
        run_cycle(1'b0, 1'b0, 32'h0, 8'h0);
        for (int i = 0; i < FRAME + 10; i++) run_cycle(1'b1, 1'b0, 32'h0, 8'h0);

        // Asynchronous reset during SHOW, then dark until load + enable.
        run_to_pos(2 * RD + 5);
        async_reset();
        for (int i = 0; i < 12; i++) run_cycle(1'b0, 1'b0, 32'h0, 8'h0);
        run_cycle(1'b1, 1'b1, 32'hCAFE_F00D, 8'h42);
        for (int i = 0; i < FRAME + 4; i++) run_cycle(1'b1, 1'b0, 32'h0, 8'h0);

        // Randomized traffic, biased toward loads in the wrap cycle.
        for (int i = 0; i < 3000; i++) begin
            logic e_v, l_v;
            if (m_run) e_v = ($urandom_range(0, 299) != 0);
            else       e_v = ($urandom_range(0, 3) != 0);
            if (m_run && model_pos() == FRAME - 1) l_v = $urandom_range(0, 1) != 0;
            else                                   l_v = ($urandom_range(0, 39) == 0);
            run_cycle(e_v, l_v, $urandom, 8'($urandom));
            if (m_run && (model_pos() % RD) >= BC && $urandom_range(0, 599) == 0) begin
                async_reset();
            end
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
